// File: rtl/fec_encoder.sv
// fec_encoder: encodes 8-bit messages into 16-bit codewords and holds them
// in a two-entry FIFO. The codeword has seven data bits in the upper byte,
// four Hamming-style parity bits at c[8], c[4], c[2] and c[1], and an
// overall even-parity bit in c[0].
// Producer side: en/req/data_in, with a registered one-cycle ack per accept.
// Consumer side: code_valid/code_ready/code_out.
// Optional feature: define FEC_ENCODER_ERR_INJECT_EN to add an inj_mask input.
// That mask is XORed into each codeword as it is stored, for error injection.

package fec_encoder_pkg;
   typedef logic [7:0]  message_data_t;
   typedef logic [15:0] demodulated_message_data_t;
endpackage

module fec_encoder
   import fec_encoder_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      en,
   input  logic                      req,
   input  message_data_t             data_in,
`ifdef FEC_ENCODER_ERR_INJECT_EN
   input  logic [15:0]               inj_mask,
`endif
   output logic                      ack,
   output logic                      code_valid,
   input  logic                      code_ready,
   output demodulated_message_data_t code_out,
   output logic                      full
);

   // Build the 16-bit codeword from an 8-bit message. The message is
   // zero-extended to 11 bits (m[10:8] = 0) before encoding.
   function automatic demodulated_message_data_t encode(input message_data_t d);
      logic [10:0]               m;
      demodulated_message_data_t c;
      m        = {3'b000, d};
      c        = '0;
      c[15:9]  = m[10:4];
      c[7:5]   = m[3:1];
      c[3]     = m[0];
      c[8]     = ^m[10:4];
      c[4]     = ^{m[10:7], m[3:1]};
      c[2]     = ^{m[10:9], m[6:5], m[3:2], m[0]};
      c[1]     = ^{m[10], m[8], m[6], m[4:3], m[1:0]};
      c[0]     = ^c[15:1];
      return c;
   endfunction

   demodulated_message_data_t entries [2];
   logic                      wr_ptr;
   logic                      rd_ptr;
   logic [1:0]                count;
   logic                      push;
   logic                      pop;
   demodulated_message_data_t store_word;

   // Handshake decode and the value written into the FIFO on a push.
   always_comb begin
      // NOTE: every signal gets a default first, so no path leaves it unassigned and no latch is inferred.
      push       = 1'b0;
      pop        = 1'b0;
      store_word = encode(data_in);
      // The count is sampled before this cycle's pop, so a full FIFO refuses a
      // push even when the consumer drains it on the same edge.
      if (en && req && (count != 2'd2))
         push = 1'b1;
      // A code_ready with nothing buffered is ignored, so count cannot underflow.
      if ((count != 2'd0) && code_ready)
         pop = 1'b1;
`ifdef FEC_ENCODER_ERR_INJECT_EN
      store_word = encode(data_in) ^ inj_mask;
`endif
   end

   // FIFO storage, pointers, occupancy count and registered acknowledge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the two storage entries are reset too, so code_out reads 16'h0000 out of reset and no stale codeword survives.
         entries[0] <= '0;
         entries[1] <= '0;
         wr_ptr     <= 1'b0;
         rd_ptr     <= 1'b0;
         count      <= 2'd0;
         ack        <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments, so every register here sees the pre-edge values.
         ack <= push;
         if (push) begin
            entries[wr_ptr] <= store_word;
            wr_ptr          <= ~wr_ptr;
         end
         if (pop)
            rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // Consumer-facing status and head-of-queue data.
   always_comb begin
      code_valid = (count != 2'd0);
      full       = (count == 2'd2);
      code_out   = entries[rd_ptr];
   end

endmodule

// File: doc/fec_encoder.md
FEC_ENCODER -- requirements
Module: fec_encoder

Interface
REQ-001 SHALL have ports: clk  input  1  sole clock, all state on rising edge.
REQ-002 SHALL have: rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have: en  input  1  block enable, gates acceptance of new messages.
REQ-004 SHALL have: req  input  1  producer request, data_in valid while high.
REQ-005 SHALL have: data_in  input  8 (message_data_t)  message byte to encode.
REQ-006 SHALL have: ack  output  1  registered one-cycle acceptance pulse.
REQ-007 SHALL have: code_valid  output  1  head codeword available.
REQ-008 SHALL have: code_ready  input  1  consumer accepts head codeword.
REQ-009 SHALL have: code_out  output  16 (demodulated_message_data_t)  head codeword.
REQ-010 SHALL have: full  output  1  buffer holds 2 entries.

Function
REQ-011 SHALL form message m[10:0] = {3'b000, data_in[7:0]}.
REQ-012 SHALL place data bits: c[15:9]=m[10:4], c[7:5]=m[3:1], c[3]=m[0].
REQ-013 SHALL compute c[8]=XOR(m[10:4]); c[4]=XOR(m[10:7],m[3:1]).
REQ-014 SHALL compute c[2]=XOR(m[10:9],m[6:5],m[3:2],m[0]); c[1]=XOR(m[10],m[8],m[6],m[4:3],m[1:0]).
REQ-015 SHALL compute overall parity c[0]=XOR(c[15:1]), giving even parity over all 16 bits.
REQ-016 SHALL buffer codewords in a 2-entry FIFO (write ptr, read ptr, 2-bit count 0..2).
REQ-017 SHALL accept (push) in a cycle where en & req & (count<2), count taken before that cycle's pop.
REQ-018 SHALL drive ack=1 for exactly the cycle after each accept, 0 otherwise; back-to-back accepts give consecutive ack pulses.
REQ-019 SHALL hold req with no ack when full or en=0; no push, no data loss in FIFO.
REQ-020 SHALL drive code_valid=(count!=0) and code_out=entry at read ptr; code_out stable while code_valid & ~code_ready.
REQ-021 SHALL pop when code_valid & code_ready; push and pop in the same cycle leave count unchanged.
REQ-022 SHALL present first codeword on code_valid one cycle after the accepting edge (latency 1).
REQ-023 SHALL drive full=(count==2); pointers wrap modulo 2.
REQ-024 SHALL keep draining the output side when en=0.
REQ-025 SHALL ignore code_ready while code_valid=0 (no underflow, count never below 0).

Reset
REQ-026 SHALL on rst_n low asynchronously clear: ack=0, code_valid=0, full=0, count=0, pointers=0, code_out=16'h0000.
REQ-027 SHALL discard buffered codewords on reset mid-operation; first accept after release behaves as from empty.

Configuration
REQ-028 SHALL, with macro FEC_ENCODER_ERR_INJECT_EN defined, add input inj_mask[15:0] XORed into the codeword at push time (stored value = codeword ^ inj_mask).
REQ-029 SHALL, without FEC_ENCODER_ERR_INJECT_EN, have no inj_mask port and store the unmodified codeword.

Verification
REQ-030 Reset, then en=1, req=1, data_in=8'hA5, code_ready=1 -> ack=1 next cycle, code_valid=1 with code_out=16'h144E.
REQ-031 data_in=8'h00 then 8'hFF back-to-back -> code_out 16'h0000 then 16'h1EEE, two consecutive ack pulses.
REQ-032 code_ready=0, req held with 3 messages -> two acks, full=1, third held unacked; raise code_ready -> FIFO order preserved, third accepted.
REQ-033 Full FIFO, req=1 and code_ready=1 same cycle -> pop only, no ack that cycle, ack next cycle after slot frees.
REQ-034 Assert rst_n low with 2 entries buffered -> code_valid=0, full=0 immediately; no stale codeword after release.
REQ-035 With FEC_ENCODER_ERR_INJECT_EN, data_in=8'hA5, inj_mask=16'h0020 -> code_out=16'h146E.
